// File: rtl/rtc_bus_sequencer.sv
// Request/done bus master for the RTC chip's multiplexed AD/CS/WR/RD bus.
// Runs an address phase and a data phase per beat and auto-increments the address across a burst.
module rtc_bus_sequencer #(
    parameter int DW      = 8,
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 4,
    parameter int BW      = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          rw,
    input  logic [DW-1:0] addr,
    input  logic [BW-1:0] burst_len,
    input  logic [DW-1:0] wdata,
    output logic          wr_taken,
    output logic [DW-1:0] rdata,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic          AD,
    output logic          CS,
    output logic          WR,
    output logic          RD,
    inout  wire  [DW-1:0] salient
);

    localparam int T_MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX_HG = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int T_MAX    = (T_MAX_SP > T_MAX_HG) ? T_MAX_SP : T_MAX_HG;
    localparam int CW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [3:0] {
        IDLE,
        A_SETUP,
        A_PULSE,
        A_HOLD,
        GAP1,
        D_SETUP,
        D_PULSE,
        D_HOLD,
        GAP2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW:0]   beats_q, beats_d;
    logic [DW-1:0] cur_addr_q, cur_addr_d;
    logic          rw_q, rw_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] bus_q, bus_d;
    logic          oe_q, oe_d;
    logic [DW-1:0] rdata_d;
    logic          rd_valid_d, wr_taken_d, done_d, busy_d;
    logic          ad_d, cs_d, wr_d, rd_d;
    logic          a_phase, d_phase;
    logic          cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // Each timed state holds for T_x cycles: the counter is loaded with T_x-1 on entry.
    function automatic logic [CW-1:0] entry_count(input state_t s);
        logic [CW-1:0] c;
        c = '0;
        case (s)
            A_SETUP, D_SETUP: c = CW'(T_SETUP - 1);
            A_PULSE, D_PULSE: c = CW'(T_PULSE - 1);
            A_HOLD,  D_HOLD:  c = CW'(T_HOLD - 1);
            GAP1,    GAP2:    c = CW'(T_GAP - 1);
            default:          c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: every combinational output is given a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        beats_d    = beats_q;
        cur_addr_d = cur_addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata;
        rd_valid_d = 1'b0;
        wr_taken_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // A request arriving in the done cycle waits for the next IDLE cycle.
                if (req && !done) begin
                    state_d    = A_SETUP;
                    rw_d       = rw;
                    cur_addr_d = addr;
                    beats_d    = (burst_len == '0) ? (BW+1)'(1) : {1'b0, burst_len};
                end
            end
            A_SETUP: if (cnt_zero) state_d = A_PULSE;
            A_PULSE: if (cnt_zero) state_d = A_HOLD;
            A_HOLD:  if (cnt_zero) state_d = GAP1;
            GAP1:    if (cnt_zero) state_d = D_SETUP;
            D_SETUP: if (cnt_zero) state_d = D_PULSE;
            D_PULSE: begin
                if (cnt_zero) begin
                    state_d = D_HOLD;
                    if (rw_q) begin
                        rdata_d    = salient;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            D_HOLD: begin
                if (cnt_zero) begin
                    if (beats_q > (BW+1)'(1)) begin
                        state_d    = GAP2;
                        beats_d    = beats_q - (BW+1)'(1);
                        cur_addr_d = cur_addr_q + DW'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            GAP2:    if (cnt_zero) state_d = A_SETUP;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = entry_count(state_d);
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - CW'(1);
        end

        if (state_d == D_SETUP && state_q != D_SETUP && !rw_q) begin
            wdata_d    = wdata;
            wr_taken_d = 1'b1;
        end

        // Pin values are decoded from the next state so that every pin comes straight from a flop.
        a_phase = (state_d == A_SETUP) || (state_d == A_PULSE) || (state_d == A_HOLD);
        d_phase = (state_d == D_SETUP) || (state_d == D_PULSE) || (state_d == D_HOLD);
        ad_d    = !a_phase;
        cs_d    = !(a_phase || d_phase);
        wr_d    = !((state_d == A_PULSE) || (state_d == D_PULSE && !rw_d));
        rd_d    = !(state_d == D_PULSE && rw_d);
        oe_d    = a_phase || (d_phase && !rw_d);
        bus_d   = a_phase ? cur_addr_d : wdata_d;
        busy_d  = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            beats_q    <= '0;
            cur_addr_q <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            bus_q      <= '0;
            oe_q       <= 1'b0;
            rdata      <= '0;
            rd_valid   <= 1'b0;
            wr_taken   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            AD         <= 1'b1;
            CS         <= 1'b1;
            WR         <= 1'b1;
            RD         <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beats_q    <= beats_d;
            cur_addr_q <= cur_addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            bus_q      <= bus_d;
            oe_q       <= oe_d;
            rdata      <= rdata_d;
            rd_valid   <= rd_valid_d;
            wr_taken   <= wr_taken_d;
            done       <= done_d;
            busy       <= busy_d;
            AD         <= ad_d;
            CS         <= cs_d;
            WR         <= wr_d;
            RD         <= rd_d;
        end
    end

    assign salient = oe_q ? bus_q : {DW{1'bz}};

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: an RTC bus model plus scoreboard queues of expected
// addresses, write data and read data, checked by a negedge protocol monitor.
module tb_rtc_bus_sequencer;

    localparam int DW      = 8;
    localparam int BW      = 3;
    localparam int T_SETUP = 2;
    localparam int T_PULSE = 4;
    localparam int T_HOLD  = 2;
    localparam int T_GAP   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          rw = 1'b0;
    logic [DW-1:0] addr = '0;
    logic [BW-1:0] burst_len = '0;
    logic [DW-1:0] wdata = '0;
    logic          wr_taken, rd_valid, busy, done, AD, CS, WR, RD;
    logic [DW-1:0] rdata;
    wire  [DW-1:0] salient;

    // RTC model: returns fixed data or the inverted latched address while RD is low; a
    // keeper drives 0x00 while CS is high, so any DUT drive then shows up as a wrong value.
    logic          rtc_mode = 1'b0;
    logic [DW-1:0] rtc_fixed = '0;
    logic [DW-1:0] rtc_addr = '0;
    logic [DW-1:0] rtc_val;
    assign rtc_val = rtc_mode ? ~rtc_addr : rtc_fixed;
    assign salient = (RD == 1'b0) ? rtc_val : ((CS == 1'b1) ? 8'h00 : 8'hzz);

    rtc_bus_sequencer #(
        .DW(DW), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .T_GAP(T_GAP), .BW(BW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .burst_len(burst_len),
        .wdata(wdata), .wr_taken(wr_taken), .rdata(rdata), .rd_valid(rd_valid), .busy(busy),
        .done(done), .AD(AD), .CS(CS), .WR(WR), .RD(RD), .salient(salient)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    logic [DW-1:0] addr_q[$];
    logic [DW-1:0] data_q[$];
    logic [DW-1:0] rdata_q[$];

    int            wr_run = 0, rd_run = 0, gap_run = 0;
    int            wr_taken_cnt = 0, rd_valid_cnt = 0, done_cnt = 0, busy_cnt = 0, done_cyc = 0;
    logic          wr_taken_prev = 1'b0, rd_valid_prev = 1'b0, done_prev = 1'b0;
    logic [DW-1:0] exp_bus = '0;
    logic [DW-1:0] exp_rd;

    always @(negedge clk) begin
        if (reset) begin
            wr_run = 0; rd_run = 0; gap_run = 0;
            wr_taken_prev = 1'b0; rd_valid_prev = 1'b0; done_prev = 1'b0;
        end else begin
            check("wr_rd_exclusive", (WR == 1'b0 && RD == 1'b0), 0);
            if (!WR || !RD) check("strobe_needs_cs", CS, 0);

            if (!WR) begin
                if (wr_run == 0) begin
                    if (!AD) begin
                        if (addr_q.size() == 0) check("addr_q_empty", 1, 0);
                        else exp_bus = addr_q.pop_front();
                    end else begin
                        if (data_q.size() == 0) check("data_q_empty", 1, 0);
                        else exp_bus = data_q.pop_front();
                    end
                end
                if (!AD) begin
                    rtc_addr = salient;
                    check("wr_addr_bus", salient, exp_bus);
                end else begin
                    check("wr_data_bus", salient, exp_bus);
                end
                wr_run++;
            end else if (wr_run != 0) begin
                check("wr_pulse_len", wr_run, T_PULSE);
                wr_run = 0;
            end

            if (!RD) begin
                check("rd_phase_ad", AD, 1);
                check("rd_bus_model_only", salient, rtc_val);
                rd_run++;
            end else if (rd_run != 0) begin
                check("rd_pulse_len", rd_run, T_PULSE);
                rd_run = 0;
            end

            if (CS) check("bus_released", salient, 0);

            if (busy) busy_cnt++;
            if (CS && busy) begin
                gap_run++;
            end else begin
                if (!CS && gap_run != 0) check("cs_gap_len", gap_run, T_GAP);
                gap_run = 0;
            end

            if (rd_valid) begin
                rd_valid_cnt++;
                if (rdata_q.size() == 0) begin
                    check("rdata_q_empty", 1, 0);
                end else begin
                    exp_rd = rdata_q.pop_front();
                    check("rdata_value", rdata, exp_rd);
                end
            end
            if (wr_taken) wr_taken_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_clears_busy", busy, 0);
            end
            check("rd_valid_single", (rd_valid && rd_valid_prev), 0);
            check("wr_taken_single", (wr_taken && wr_taken_prev), 0);
            check("done_single", (done && done_prev), 0);
            rd_valid_prev = rd_valid;
            wr_taken_prev = wr_taken;
            done_prev     = done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request right after an edge; the accepting edge E0 is the next one.
    task automatic start(input logic r, input logic [DW-1:0] a, input logic [BW-1:0] bl,
                         input logic [DW-1:0] wd, output int e0);
        rw = r; addr = a; burst_len = bl; wdata = wd; req = 1'b1;
        e0 = cyc + 1;
        step();
        req = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input string tag);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < 300) begin
            step();
            n++;
        end
        if (done_cnt == start_cnt) check({tag, "_timeout"}, 0, 1);
        else check(tag, done_cyc, exp_cyc);
    endtask

    int e0, wt0, rv0, b0, d0;

    initial begin
        // Reset and idle
        reset = 1'b1;
        repeat (3) step();
        check("reset_pins", {AD, CS, WR, RD, busy, done, rd_valid, wr_taken}, 8'hF0);
        check("reset_rdata", rdata, 0);
        check("reset_bus", salient, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_pins", {AD, CS, WR, RD, busy, done, rd_valid, wr_taken}, 8'hF0);
        end

        // Single write
        addr_q.push_back(8'h21);
        data_q.push_back(8'h5A);
        wt0 = wr_taken_cnt; b0 = busy_cnt;
        start(1'b0, 8'h21, 3'd1, 8'h5A, e0);
        wait_done(e0 + 20, "write_done_cycle");
        check("write_wr_taken_cnt", wr_taken_cnt - wt0, 1);
        check("write_busy_cycles", busy_cnt - b0, 20);

        // Single read, model returns 0x47
        rtc_mode = 1'b0; rtc_fixed = 8'h47;
        addr_q.push_back(8'h23);
        rdata_q.push_back(8'h47);
        rv0 = rd_valid_cnt; wt0 = wr_taken_cnt;
        start(1'b1, 8'h23, 3'd1, 8'h00, e0);
        wait_done(e0 + 20, "read_done_cycle");
        check("read_rd_valid_cnt", rd_valid_cnt - rv0, 1);
        check("read_no_wr_taken", wr_taken_cnt - wt0, 0);
        check("read_rdata_holds", rdata, 8'h47);

        // Four-beat read across the address wrap, model returns ~addr
        rtc_mode = 1'b1;
        addr_q.push_back(8'hFE); addr_q.push_back(8'hFF);
        addr_q.push_back(8'h00); addr_q.push_back(8'h01);
        rdata_q.push_back(8'h01); rdata_q.push_back(8'h00);
        rdata_q.push_back(8'hFF); rdata_q.push_back(8'hFE);
        rv0 = rd_valid_cnt;
        start(1'b1, 8'hFE, 3'd4, 8'h00, e0);
        wait_done(e0 + 92, "burst_done_cycle");
        check("burst_rd_valid_cnt", rd_valid_cnt - rv0, 4);
        check("burst_last_rdata", rdata, 8'hFE);

        // Reset during the data-phase write pulse
        addr_q.push_back(8'h40);
        data_q.push_back(8'hC3);
        start(1'b0, 8'h40, 3'd1, 8'hC3, e0);
        repeat (15) step();
        check("abort_in_data_pulse", {AD, CS, WR}, 3'b100);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("abort_pins", {AD, CS, WR, RD, busy, done, rd_valid, wr_taken}, 8'hF0);
        check("abort_bus", salient, 0);
        step();
        step();
        reset = 1'b0;
        repeat (30) step();
        check("abort_no_done", done_cnt - d0, 0);

        // Write after the abort; burst_len 0 behaves as one beat
        addr_q.push_back(8'h55);
        data_q.push_back(8'h3C);
        wt0 = wr_taken_cnt;
        start(1'b0, 8'h55, 3'd0, 8'h3C, e0);
        wait_done(e0 + 20, "post_abort_done_cycle");
        check("post_abort_wr_taken_cnt", wr_taken_cnt - wt0, 1);

        // req held high: the done cycle and the IDLE cycle after it, then the next transaction
        addr_q.push_back(8'h66); addr_q.push_back(8'h66);
        data_q.push_back(8'h81); data_q.push_back(8'h81);
        rw = 1'b0; addr = 8'h66; burst_len = 3'd1; wdata = 8'h81; req = 1'b1;
        e0 = cyc + 1;
        wait_done(e0 + 20, "b2b_first_done_cycle");
        check("b2b_ignored_in_done_cycle", {busy, CS}, 2'b01);
        step();
        check("b2b_second_started", {busy, CS}, 2'b10);
        step();
        req = 1'b0;
        wait_done(e0 + 42, "b2b_second_done_cycle");

        repeat (3) step();
        check("addr_q_drained", addr_q.size(), 0);
        check("data_q_drained", data_q.size(), 0);
        check("rdata_q_drained", rdata_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
